// File: rtl/hw4_pkg.sv
// Shared types and helpers for the delay timer controller.
package hw4_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_t;

   // Prescaler must hold 0..tickDiv-1 and is never narrower than one bit.
   function automatic int prescWidth(input int tickDiv);
      int w;
      w = $clog2(tickDiv);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/downcount.sv
// Loadable n-bit down counter: load has priority over decrement.
module downcount #(
   parameter int n = 8
) (
   input  logic [n-1:0] R,
   input  logic         Clock,
   input  logic         L,
   input  logic         E,
   output logic [n-1:0] Q
);

   always_ff @(posedge Clock) begin
      if (L)
         Q <= R;
      else if (E)
         Q <= Q - n'(1);
   end

endmodule

// File: rtl/delay_timer_ctrl.sv
// Turns a start request into delay x TICK_DIV clock cycles of busy, then a one-cycle done.
module delay_timer_ctrl
   import hw4_pkg::*;
#(
   parameter int N        = 8,
   parameter int TICK_DIV = 50000
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         start,
   input  logic         cancel,
   input  logic [N-1:0] delay,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] remaining
);

   localparam int            PW         = prescWidth(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   timer_state_t  state;
   timer_state_t  stateNext;
   logic [PW-1:0] prescaler;
   logic [PW-1:0] prescNext;
   logic [N-1:0]  count;
   logic [N-1:0]  cntValue;
   logic          cntLoad;
   logic          cntEnable;
   logic          tick;

   // With TICK_DIV = 1 the prescaler never leaves 0, so every RUN cycle ticks.
   assign tick = (prescaler == PRESC_LAST);

   // Counter controls come straight from next-state logic; reset forces a load of zero.
   always_comb begin
      stateNext = state;
      prescNext = prescaler;
      cntLoad   = 1'b0;
      cntEnable = 1'b0;
      cntValue  = '0;
      if (Reset) begin
         cntLoad   = 1'b1;
         stateNext = IDLE;
         prescNext = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cntLoad   = 1'b1;
                  cntValue  = delay;
                  prescNext = '0;
                  stateNext = (delay != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (cancel) begin
                  cntLoad   = 1'b1;
                  prescNext = '0;
                  stateNext = IDLE;
               end else if (tick) begin
                  prescNext = '0;
                  cntEnable = (count != '0);
                  if (count == N'(1))
                     stateNext = DONE;
               end else begin
                  prescNext = prescaler + PW'(1);
               end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         prescaler <= '0;
      end else begin
         state     <= stateNext;
         prescaler <= prescNext;
      end
   end

   downcount #(
      .n(N)
   ) counter (
      .R     (cntValue),
      .Clock (Clock),
      .L     (cntLoad),
      .E     (cntEnable),
      .Q     (count)
   );

   assign busy      = (state == RUN);
   assign done      = (state == DONE);
   assign remaining = count;

endmodule

// File: tb/tb_delay_timer_ctrl.sv
// Scoreboard bench: stimulus queues expected snapshots per cycle, a monitor checks them.
module tb_delay_timer_ctrl;

   logic       Clock;
   logic       resetA, resetB;
   logic       startA, startB;
   logic       cancelA, cancelB;
   logic [2:0] delayA, delayB;
   logic       busyA, busyB;
   logic       doneA, doneB;
   logic [2:0] remA, remB;

   typedef struct {
      int cyc;
      int rem;
      int busy;
      int done;
   } expect_t;

   expect_t qa[$];
   expect_t qb[$];
   int      dqa[$];
   int      dqb[$];
   int      cyc   = 0;
   int      base  = 0;
   int      nVec  = 0;
   int      nFail = 0;

   delay_timer_ctrl #(.N(3), .TICK_DIV(4)) dutA (
      .Clock     (Clock),
      .Reset     (resetA),
      .start     (startA),
      .cancel    (cancelA),
      .delay     (delayA),
      .busy      (busyA),
      .done      (doneA),
      .remaining (remA)
   );

   delay_timer_ctrl #(.N(3), .TICK_DIV(1)) dutB (
      .Clock     (Clock),
      .Reset     (resetB),
      .start     (startB),
      .cancel    (cancelB),
      .delay     (delayB),
      .busy      (busyB),
      .done      (doneB),
      .remaining (remB)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVec++;
      if (actual !== expected) begin
         nFail++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, actual, expected);
      end
   endtask

   // Expectations are addressed by edge index k relative to the current scenario's edge 0.
   function automatic void pushA(input int k, input int rem, input int busy, input int done);
      qa.push_back('{base + 1 + k, rem, busy, done});
   endfunction

   function automatic void pushB(input int k, input int rem, input int busy, input int done);
      qb.push_back('{base + 1 + k, rem, busy, done});
   endfunction

   task automatic gotoEdge(input int k);
      while (cyc < base + k) @(negedge Clock);
   endtask

   task automatic applyStimulus(input int which, input logic s, input logic c, input logic [2:0] d);
      if (which == 0) begin
         startA = s; cancelA = c; delayA = d;
      end else begin
         startB = s; cancelB = c; delayB = d;
      end
   endtask

   // Monitor: outputs are sampled 3 time units after each rising edge.
   always @(posedge Clock) begin
      expect_t e;
      cyc = cyc + 1;
      #3;
      while (qa.size() > 0 && qa[0].cyc <= cyc) begin
         e = qa.pop_front();
         if (e.cyc < cyc) begin
            nVec++; nFail++;
            $display("[TB] FAIL A.stale entry for cycle %0d seen at %0d", e.cyc, cyc);
         end else begin
            checkOutput("A.remaining", 32'(remA), e.rem);
            checkOutput("A.busy", 32'(busyA), e.busy);
            checkOutput("A.done", 32'(doneA), e.done);
         end
      end
      while (qb.size() > 0 && qb[0].cyc <= cyc) begin
         e = qb.pop_front();
         if (e.cyc < cyc) begin
            nVec++; nFail++;
            $display("[TB] FAIL B.stale entry for cycle %0d seen at %0d", e.cyc, cyc);
         end else begin
            checkOutput("B.remaining", 32'(remB), e.rem);
            checkOutput("B.busy", 32'(busyB), e.busy);
            checkOutput("B.done", 32'(doneB), e.done);
         end
      end
      if (doneA === 1'b1) begin
         if (dqa.size() == 0) begin
            nVec++; nFail++;
            $display("[TB] FAIL A.unexpected_done at cycle %0d: got 1, want 0", cyc);
         end else
            checkOutput("A.done_cycle", cyc, dqa.pop_front());
      end
      if (doneB === 1'b1) begin
         if (dqb.size() == 0) begin
            nVec++; nFail++;
            $display("[TB] FAIL B.unexpected_done at cycle %0d: got 1, want 0", cyc);
         end else
            checkOutput("B.done_cycle", cyc, dqb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      resetA = 1'b1; resetB = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      applyStimulus(1, 1'b0, 1'b0, 3'd0);
      base = 0;
      for (int k = 0; k < 2; k++) begin
         pushA(k, 0, 0, 0);
         pushB(k, 0, 0, 0);
      end
      gotoEdge(2);
      resetA = 1'b0; resetB = 1'b0;
      @(negedge Clock);

      // delay 3 on a divide-by-4 timer: decrements at edges 4, 8, 12
      $display("[TB] delay=3 basic timing");
      base = cyc;
      applyStimulus(0, 1'b1, 1'b0, 3'd3);
      pushA(0, 3, 1, 0);  pushA(3, 3, 1, 0);
      pushA(4, 2, 1, 0);  pushA(7, 2, 1, 0);
      pushA(8, 1, 1, 0);  pushA(11, 1, 1, 0);
      pushA(12, 0, 0, 1); pushA(13, 0, 0, 0);
      dqa.push_back(base + 13);
      gotoEdge(1);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(15);

      $display("[TB] delay=0 goes straight to done");
      base = cyc;
      applyStimulus(0, 1'b1, 1'b0, 3'd0);
      pushA(0, 0, 0, 1); pushA(1, 0, 0, 0);
      dqa.push_back(base + 1);
      gotoEdge(1);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(3);

      $display("[TB] cancel with remaining=4");
      base = cyc;
      applyStimulus(0, 1'b1, 1'b0, 3'd5);
      pushA(0, 5, 1, 0); pushA(3, 5, 1, 0);
      pushA(4, 4, 1, 0); pushA(5, 4, 1, 0);
      pushA(6, 0, 0, 0); pushA(7, 0, 0, 0);
      pushA(10, 0, 0, 0);
      gotoEdge(1);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(6);
      applyStimulus(0, 1'b0, 1'b1, 3'd0);
      gotoEdge(7);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(11);

      $display("[TB] start ignored mid-RUN and during DONE");
      base = cyc;
      applyStimulus(0, 1'b1, 1'b0, 3'd2);
      pushA(0, 2, 1, 0); pushA(3, 2, 1, 0);
      pushA(4, 1, 1, 0); pushA(7, 1, 1, 0);
      pushA(8, 0, 0, 1); pushA(9, 0, 0, 0);
      pushA(10, 0, 0, 0);
      dqa.push_back(base + 9);
      gotoEdge(1);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(3);
      applyStimulus(0, 1'b1, 1'b0, 3'd7);
      gotoEdge(4);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(9);
      applyStimulus(0, 1'b1, 1'b0, 3'd7);
      gotoEdge(10);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(12);

      $display("[TB] reset mid-RUN then restart");
      base = cyc;
      applyStimulus(0, 1'b1, 1'b0, 3'd3);
      pushA(0, 3, 1, 0); pushA(4, 2, 1, 0);
      pushA(5, 2, 1, 0); pushA(6, 0, 0, 0);
      pushA(7, 0, 0, 0);
      gotoEdge(1);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(6);
      resetA = 1'b1;
      gotoEdge(7);
      resetA = 1'b0;
      gotoEdge(8);
      base = cyc;
      applyStimulus(0, 1'b1, 1'b0, 3'd1);
      pushA(0, 1, 1, 0); pushA(3, 1, 1, 0);
      pushA(4, 0, 0, 1); pushA(5, 0, 0, 0);
      dqa.push_back(base + 5);
      gotoEdge(1);
      applyStimulus(0, 1'b0, 1'b0, 3'd0);
      gotoEdge(7);

      // TICK_DIV = 1: one decrement per cycle, then a back-to-back start
      $display("[TB] TICK_DIV=1 max delay and back-to-back start");
      base = cyc;
      applyStimulus(1, 1'b1, 1'b0, 3'd7);
      for (int k = 0; k < 7; k++) pushB(k, 7 - k, 1, 0);
      pushB(7, 0, 0, 1); pushB(8, 0, 0, 0);
      dqb.push_back(base + 8);
      gotoEdge(1);
      applyStimulus(1, 1'b0, 1'b0, 3'd0);
      gotoEdge(9);
      applyStimulus(1, 1'b1, 1'b0, 3'd2);
      pushB(9, 2, 1, 0); pushB(10, 1, 1, 0);
      pushB(11, 0, 0, 1); pushB(12, 0, 0, 0);
      dqb.push_back(base + 12);
      gotoEdge(10);
      applyStimulus(1, 1'b0, 1'b0, 3'd0);
      gotoEdge(14);

      checkOutput("A.pending", 32'(qa.size() + dqa.size()), 0);
      checkOutput("B.pending", 32'(qb.size() + dqb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
